// File: rtl/sm83_bus_seq.sv
// sm83_bus_seq: SM83-side bus master for dmg_cpu_b.
// Queued NOP/READ/WRITE commands are replayed on the CPU bus in step with
// the T2/T3/T5/T10 machine-cycle phase clocks. Read data is returned on rsp_*.
// Optional read-check logic is enabled by defining SM83_BUS_SEQ_RDCHK_EN.
module sm83_bus_seq #(
   parameter int DEPTH     = 4,
   parameter int BOOT_NOPS = 2
) (
   input  logic        xi,
   input  logic        cpu_in_t13,
   input  logic        cpu_in_t12,
   input  logic        cpu_clkin_t2,
   input  logic        cpu_clkin_t3,
   input  logic        cpu_clkin_t5,
   input  logic        cpu_clkin_t10,
   input  logic        cpu_in_t15,
   input  logic        cpu_in_r4,
   input  logic        cpu_in_r5,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [1:0]  cmd_op,
   input  logic [15:0] cmd_adr,
   input  logic [7:0]  cmd_dat,
   output logic        rsp_valid,
   output logic [7:0]  rsp_dat,
   output logic [15:0] cpu_a,
   inout  wire  [7:0]  cpu_d,
   output logic        cpu_raw_rd,
   output logic        cpu_raw_wr,
   output logic        cpu_out_r7,
   output logic        cpu_clk_ena,
   output logic        rd_mismatch,
   output logic [15:0] err_cnt
);

   localparam int AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW  = AW + 1;
   localparam int WCW = (BOOT_NOPS > 1) ? $clog2(BOOT_NOPS) : 1;
   localparam logic [WCW-1:0] WLAST = WCW'((BOOT_NOPS > 0) ? (BOOT_NOPS - 1) : 0);
   localparam logic [1:0] OP_READ  = 2'd1;
   localparam logic [1:0] OP_WRITE = 2'd2;

   typedef enum logic [1:0] {
      S_BOOT  = 2'd0,
      S_WARM  = 2'd1,
      S_IDLE  = 2'd2,
      S_CYCLE = 2'd3
   } state_t;

   state_t          state_q;
   logic [WCW-1:0]  warm_cnt_q;
   logic            clk_ena_q;
   logic [15:0]     a_q;
   logic [7:0]      dout_q;
   logic [7:0]      cyc_dat_q;
   logic            rd_cyc_q;
   logic            wr_cyc_q;
   logic            rsp_valid_q;
   logic [7:0]      rsp_dat_q;

   // previous levels of the phase clocks for rise detection
   logic t2_q, t3_q, t5_q, t10_q;
   logic t2_rise, t3_rise, t5_rise, t10_rise;

   // command FIFO
   logic [1:0]    op_mem  [DEPTH];
   logic [15:0]   adr_mem [DEPTH];
   logic [7:0]    dat_mem [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          fifo_empty;
   logic          push;
   logic          pop;
   logic          issue_slot;
   logic [1:0]    head_op;
   logic [15:0]   head_adr;
   logic [7:0]    head_dat;
   logic          drive;

   assign t2_rise  = cpu_clkin_t2  & ~t2_q;
   assign t3_rise  = cpu_clkin_t3  & ~t3_q;
   assign t5_rise  = cpu_clkin_t5  & ~t5_q;
   assign t10_rise = cpu_clkin_t10 & ~t10_q;

   assign fifo_empty = (cnt_q == '0);
   assign cmd_ready  = (cnt_q != CW'(DEPTH));
   assign push       = cmd_valid & cmd_ready;
   // a new command may start on a t3 rise while idle, or on the t3 rise that
   // coincides with the t2 rise closing the current cycle
   assign issue_slot = t3_rise & ~cpu_in_t12 &
                       ((state_q == S_IDLE) | ((state_q == S_CYCLE) & t2_rise));
   assign pop        = issue_slot & ~fifo_empty;

   assign head_op  = op_mem[rd_ptr_q];
   assign head_adr = adr_mem[rd_ptr_q];
   assign head_dat = dat_mem[rd_ptr_q];

   // phase clock edge-detect history
   always_ff @(posedge xi or posedge cpu_in_t13) begin
      if (cpu_in_t13) begin
         t2_q  <= 1'b0;
         t3_q  <= 1'b0;
         t5_q  <= 1'b0;
         t10_q <= 1'b0;
      end else begin
         t2_q  <= cpu_clkin_t2;
         t3_q  <= cpu_clkin_t3;
         t5_q  <= cpu_clkin_t5;
         t10_q <= cpu_clkin_t10;
      end
   end

   // FIFO pointer and occupancy next-state
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
         2'b10:   cnt_d = cnt_q + 1'b1;
         2'b01:   cnt_d = cnt_q - 1'b1;
         default: cnt_d = cnt_q;
      endcase
   end

   // FIFO control state
   always_ff @(posedge xi or posedge cpu_in_t13) begin
      if (cpu_in_t13) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   // FIFO storage, data only so no reset
   always_ff @(posedge xi) begin
      if (push) begin
         op_mem[wr_ptr_q]  <= cmd_op;
         adr_mem[wr_ptr_q] <= cmd_adr;
         dat_mem[wr_ptr_q] <= cmd_dat;
      end
   end

`ifdef SM83_BUS_SEQ_RDCHK_EN
   logic        mis_q;
   logic [15:0] err_q;
`endif

   // bus sequencer FSM with registered bus state and response outputs
   always_ff @(posedge xi or posedge cpu_in_t13) begin
      if (cpu_in_t13) begin
         state_q     <= S_BOOT;
         warm_cnt_q  <= '0;
         clk_ena_q   <= 1'b0;
         a_q         <= '0;
         dout_q      <= '0;
         cyc_dat_q   <= '0;
         rd_cyc_q    <= 1'b0;
         wr_cyc_q    <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_dat_q   <= '0;
`ifdef SM83_BUS_SEQ_RDCHK_EN
         mis_q       <= 1'b0;
         err_q       <= '0;
`endif
      end else begin
         rsp_valid_q <= 1'b0;
`ifdef SM83_BUS_SEQ_RDCHK_EN
         mis_q       <= 1'b0;
`endif
         case (state_q)
            S_BOOT: begin
               if (t10_rise & cpu_in_t15) begin
                  clk_ena_q <= 1'b1;
                  state_q   <= (BOOT_NOPS == 0) ? S_IDLE : S_WARM;
               end
            end
            S_WARM: begin
               if (t3_rise) begin
                  if (warm_cnt_q == WLAST) state_q <= S_IDLE;
                  else                     warm_cnt_q <= warm_cnt_q + 1'b1;
               end
            end
            default: begin
               if (cpu_in_t12) begin
                  // abort: drop the cycle, keep the address, report nothing
                  if (state_q == S_CYCLE) begin
                     state_q  <= S_IDLE;
                     rd_cyc_q <= 1'b0;
                     wr_cyc_q <= 1'b0;
                  end
               end else begin
                  if ((state_q == S_CYCLE) && t2_rise) begin
                     state_q  <= S_IDLE;
                     rd_cyc_q <= 1'b0;
                     wr_cyc_q <= 1'b0;
                     if (rd_cyc_q) begin
                        rsp_valid_q <= 1'b1;
                        rsp_dat_q   <= cpu_d;
`ifdef SM83_BUS_SEQ_RDCHK_EN
                        if (cpu_d != cyc_dat_q) begin
                           mis_q <= 1'b1;
                           if (err_q != 16'hFFFF) err_q <= err_q + 1'b1;
                        end
`endif
                     end
                     // outside the high page the upper address byte parks at zero
                     if (!cpu_in_r4 && !cpu_in_r5) a_q[15:8] <= 8'h00;
                  end
                  if ((state_q == S_CYCLE) && t5_rise && wr_cyc_q) dout_q <= cyc_dat_q;
                  if (pop) begin
                     state_q   <= S_CYCLE;
                     a_q       <= head_adr;
                     cyc_dat_q <= head_dat;
                     rd_cyc_q  <= (head_op == OP_READ);
                     wr_cyc_q  <= (head_op == OP_WRITE);
                     if (head_op == OP_WRITE) dout_q <= 8'hFF;
                  end
               end
            end
         endcase
      end
   end

   assign drive       = wr_cyc_q & cpu_clkin_t3 & ~cpu_clkin_t2 & ~cpu_in_t12 & ~cpu_in_t13;
   assign cpu_d       = drive ? dout_q : 8'hzz;
   assign cpu_raw_wr  = drive;
   assign cpu_raw_rd  = rd_cyc_q & ~cpu_in_t12 & ~cpu_in_t13;
   assign cpu_out_r7  = (rd_cyc_q | wr_cyc_q) & ~cpu_in_r4 & ~cpu_in_r5 & ~cpu_in_t12 & ~cpu_in_t13;
   assign cpu_a       = a_q;
   assign cpu_clk_ena = clk_ena_q;
   assign rsp_valid   = rsp_valid_q;
   assign rsp_dat     = rsp_dat_q;

`ifdef SM83_BUS_SEQ_RDCHK_EN
   assign rd_mismatch = mis_q;
   assign err_cnt     = err_q;
`else
   assign rd_mismatch = 1'b0;
   assign err_cnt     = 16'h0000;
`endif

endmodule

// File: tb/tb_sm83_bus_seq.sv
// tb_sm83_bus_seq: directed + randomized bench for sm83_bus_seq with a
// transaction-level reference model (command queue, machine-cycle schedule).
module tb_sm83_bus_seq;

   localparam int DEPTH = 4;
   localparam int BOOT_NOPS = 2;
   localparam logic [1:0] OP_NOP = 2'd0;
   localparam logic [1:0] OP_RD  = 2'd1;
   localparam logic [1:0] OP_WR  = 2'd2;

   typedef struct packed {
      logic [1:0]  op;
      logic [15:0] adr;
      logic [7:0]  dat;
      logic [7:0]  drv;
   } cmd_t;

   logic        xi = 1'b0;
   logic        rst = 1'b1;
   logic        t12 = 1'b0;
   logic        t2 = 1'b0, t3 = 1'b0, t5 = 1'b0, t10 = 1'b0;
   logic        t15 = 1'b0;
   logic        r4;
   logic        r5 = 1'b0;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic [1:0]  cmd_op = 2'd0;
   logic [15:0] cmd_adr = 16'h0;
   logic [7:0]  cmd_dat = 8'h0;
   logic [7:0]  cmd_drv = 8'h0;
   logic        rsp_valid;
   logic [7:0]  rsp_dat;
   logic [15:0] cpu_a;
   wire  [7:0]  cpu_d;
   logic        cpu_raw_rd, cpu_raw_wr, cpu_out_r7, cpu_clk_ena;
   logic        rd_mismatch;
   logic [15:0] err_cnt;
   logic [7:0]  rd_val = 8'h00;

   int checks = 0;
   int errors = 0;
   int ph = 3;

   // reference model state
   cmd_t        q[$];
   cmd_t        m_cur;
   bit          m_cur_v = 0;
   bit          m_en = 0;
   int          m_nops = BOOT_NOPS;
   logic [15:0] m_a = 16'h0;
   logic [7:0]  m_dout = 8'h0;
   bit          m_rsp_v = 0;
   logic [7:0]  m_rsp_d = 8'h0;
   bit          m_mis = 0;
   int          m_err = 0;
   bit          acc = 0;

   always #5 xi = ~xi;

   // the chip decodes FExx/FFxx from the address bus
   assign r4 = (cpu_a[15:9] == 7'h7F);
   // memory answers whenever a read strobe is up
   assign cpu_d = cpu_raw_rd ? rd_val : 8'hzz;

   sm83_bus_seq #(.DEPTH(DEPTH), .BOOT_NOPS(BOOT_NOPS)) dut (
      .xi(xi), .cpu_in_t13(rst), .cpu_in_t12(t12),
      .cpu_clkin_t2(t2), .cpu_clkin_t3(t3), .cpu_clkin_t5(t5), .cpu_clkin_t10(t10),
      .cpu_in_t15(t15), .cpu_in_r4(r4), .cpu_in_r5(r5),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
      .cmd_adr(cmd_adr), .cmd_dat(cmd_dat),
      .rsp_valid(rsp_valid), .rsp_dat(rsp_dat),
      .cpu_a(cpu_a), .cpu_d(cpu_d),
      .cpu_raw_rd(cpu_raw_rd), .cpu_raw_wr(cpu_raw_wr),
      .cpu_out_r7(cpu_out_r7), .cpu_clk_ena(cpu_clk_ena),
      .rd_mismatch(rd_mismatch), .err_cnt(err_cnt)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // strobes and bus contents implied by the model's current cycle
   task automatic comb_checks();
      bit isr, isw, ewr;
      isr = m_cur_v && (m_cur.op == OP_RD);
      isw = m_cur_v && (m_cur.op == OP_WR);
      ewr = isw && t3 && !t2 && !t12;
      chk("raw_wr", cpu_raw_wr, ewr);
      chk("raw_rd", cpu_raw_rd, isr && !t12);
      chk("r7", cpu_out_r7, (isr || isw) && (m_a[15:9] != 7'h7F) && !r5 && !t12);
      if (ewr) chk("cpu_d", cpu_d, m_dout);
   endtask

   task automatic reg_checks();
      chk("clk_ena", cpu_clk_ena, m_en);
      chk("cmd_ready", cmd_ready, q.size() < DEPTH);
      chk("cpu_a", cpu_a, m_a);
      chk("rsp_valid", rsp_valid, m_rsp_v);
      if (m_rsp_v) chk("rsp_dat", rsp_dat, m_rsp_d);
      chk("rd_mismatch", rd_mismatch, m_mis);
      chk("err_cnt", err_cnt, 32'(m_err));
      comb_checks();
   endtask

   // one posedge of xi as seen by the machine-cycle rules
   task automatic model_edge();
      bit tr, t5r, r4m;
      int sz0;
      cmd_t c;
      tr  = (ph == 0);
      t5r = (ph == 1);
      sz0 = q.size();
      r4m = (m_a[15:9] == 7'h7F);
      m_rsp_v = 0;
      m_mis = 0;
      if (t12) m_cur_v = 0;
      else begin
         if (tr && m_cur_v) begin
            if (m_cur.op == OP_RD) begin
               m_rsp_v = 1;
               m_rsp_d = m_cur.drv;
`ifdef SM83_BUS_SEQ_RDCHK_EN
               if (m_cur.drv != m_cur.dat) begin
                  m_mis = 1;
                  if (m_err < 65535) m_err++;
               end
`endif
            end
            if (!r4m && !r5) m_a[15:8] = 8'h00;
            m_cur_v = 0;
         end
         if (t5r && m_cur_v && m_cur.op == OP_WR) m_dout = m_cur.dat;
      end
      if (tr && !t12 && m_en && m_nops == 0 && sz0 > 0) begin
         m_cur = q.pop_front();
         m_cur_v = 1;
         m_a = m_cur.adr;
         if (m_cur.op == OP_WR) m_dout = 8'hFF;
      end else if (tr && m_en && m_nops > 0) begin
         m_nops--;
      end
      if (tr && !m_en && t15) m_en = 1;
      acc = 0;
      if (cmd_valid && sz0 < DEPTH) begin
         c.op = cmd_op; c.adr = cmd_adr; c.dat = cmd_dat; c.drv = cmd_drv;
         q.push_back(c);
         acc = 1;
      end
   endtask

   // advance one xi period: phases change on negedge, state on posedge
   task automatic step();
      @(negedge xi);
      ph = (ph + 1) % 4;
      t2  = (ph == 0);
      t3  = (ph < 3);
      t5  = (ph == 1) || (ph == 2);
      t10 = (ph < 2);
      #1;
      if (!rst) comb_checks();
      @(posedge xi);
      if (!rst) model_edge();
      #1;
      if (m_cur_v) rd_val = m_cur.drv;
      if (!rst) reg_checks();
   endtask

   task automatic push(input logic [1:0] op, input logic [15:0] adr,
                       input logic [7:0] dat, input logic [7:0] drv);
      int n;
      n = 0;
      cmd_valid = 1; cmd_op = op; cmd_adr = adr; cmd_dat = dat; cmd_drv = drv;
      acc = 0;
      while (!acc && n < 300) begin
         step();
         n++;
      end
      cmd_valid = 0;
      chk("push_accept", acc, 1);
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((q.size() > 0 || m_cur_v) && n < 400) begin
         step();
         n++;
      end
      chk("drain", (q.size() == 0) && !m_cur_v, 1);
   endtask

   initial begin
      int n;
      logic [1:0]  op;
      logic [15:0] adr;
      logic [7:0]  dat;
      logic [7:0]  drv;

      // reset
      for (int i = 0; i < 6; i++) step();
      chk("rst_cpu_a", cpu_a, 16'h0000);
      chk("rst_clk_ena", cpu_clk_ena, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_dat", rsp_dat, 8'h00);
      chk("rst_raw_rd", cpu_raw_rd, 0);
      chk("rst_raw_wr", cpu_raw_wr, 0);
      chk("rst_r7", cpu_out_r7, 0);
      chk("rst_err_cnt", err_cnt, 16'h0000);
      chk("rst_mismatch", rd_mismatch, 0);
      chk("rst_cmd_ready", cmd_ready, 1);
      rst = 0;

      // oscillator not yet stable: ten t10 rises without enabling the clock
      for (int i = 0; i < 40; i++) step();
      chk("boot_hold_clk_ena", cpu_clk_ena, 0);

      // fill the FIFO while booting; the fifth waits for space
      push(OP_WR, 16'hFF80, 8'h12, 8'h00);
      push(OP_RD, 16'h1234, 8'h56, 8'h56);
      push(OP_RD, 16'h1234, 8'hAB, 8'h56);
      push(OP_WR, 16'h8000, 8'h34, 8'h00);
      chk("full_after_4", cmd_ready, 0);
      t15 = 1;
      push(OP_NOP, 16'h4321, 8'h00, 8'h00);
      drain();
      chk("clk_ena_on", cpu_clk_ena, 1);
`ifdef SM83_BUS_SEQ_RDCHK_EN
      chk("err_cnt_after_mismatch", err_cnt, 16'h0001);
`else
      chk("err_cnt_disabled", err_cnt, 16'h0000);
`endif

      // abort a write with t12, the queued read must follow on the next t3
      push(OP_WR, 16'hA000, 8'h77, 8'h00);
      push(OP_RD, 16'hC001, 8'h5A, 8'hC3);
      n = 0;
      while (!(m_cur_v && m_cur.op == OP_WR && ph == 1) && n < 100) begin
         step();
         n++;
      end
      chk("reach_write", m_cur_v && m_cur.op == OP_WR, 1);
      step();
      t12 = 1;
      #1;
      chk("abort_raw_wr", cpu_raw_wr, 0);
      chk("abort_r7", cpu_out_r7, 0);
      step();
      t12 = 0;
      drain();

      // randomized traffic with random r5, idle gaps and occasional aborts
      for (int i = 0; i < 250; i++) begin
         op  = 2'($urandom_range(0, 3));
         adr = 16'($urandom);
         if ($urandom_range(0, 3) == 0) adr[15:9] = 7'h7F;
         dat = 8'($urandom);
         drv = ($urandom_range(0, 1) == 0) ? dat : 8'($urandom);
         r5 = ($urandom_range(0, 7) == 0);
         push(op, adr, dat, drv);
         n = $urandom_range(0, 3);
         for (int g = 0; g < n; g++) begin
            t12 = ($urandom_range(0, 15) == 0);
            step();
            t12 = 0;
         end
      end
      r5 = 0;
      drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
